// File: rtl/vram_bus_responder.sv
// vram_bus_responder
// Responder side of the 68010 asynchronous bus for the video RAM window.
// A CPU cycle decoded as VRAM_b is latched, parked until the video timing
// grants a CPU slot (VRAC2=1), turned into a single one-cycle RAM access with
// byte lanes, and then acknowledged with DTACK_b after WAIT_STATES extra cycles.
// Read data is captured into a register and driven while D_OE is high.
//
// Optional feature, macro VRESP_TIMEOUT_EN:
//   when defined, a request that sees TIMEOUT consecutive cycles with no slot
//   grant is terminated with BERR_b instead of DTACK_b. When undefined, BERR_b
//   is tied high and a parked request waits for a slot indefinitely.
module vram_bus_responder #(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic          MCKR,
    input  logic          SYSRES_b,
    input  logic          AS_b,
    input  logic          UDS_b,
    input  logic          LDS_b,
    input  logic          R_b_Vs_W,
    input  logic          VRAM_b,
    input  logic [AW-1:0] A,
    input  logic [15:0]   D_in,
    output logic [15:0]   D_out,
    output logic          D_OE,
    output logic          DTACK_b,
    output logic          BERR_b,
    input  logic          VRAC2,
    output logic [AW-1:0] MEM_ADDR,
    output logic [15:0]   MEM_WDATA,
    output logic [1:0]    MEM_BE,
    output logic          MEM_EN,
    output logic          MEM_WE,
    input  logic [15:0]   MEM_RDATA
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SLOT,
        ST_MEM,
        ST_DATA,
        ST_HOLD,
        ST_ACK,
        ST_ERR
    } state_t;

    // Last value of the wait-state counter before DTACK_b is issued.
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t          state_reg;
    logic [AW-1:0]   addr_reg;
    logic [15:0]     wdata_reg;
    logic [1:0]      be_reg;
    logic            rw_reg;        // 1 = read
    logic            mem_en_reg;
    logic            mem_we_reg;
    logic [15:0]     d_out_reg;
    logic            d_oe_reg;
    logic            dtack_reg;
    logic [3:0]      wait_cnt_reg;

`ifdef VRESP_TIMEOUT_EN
    localparam int             TOW     = $clog2(TIMEOUT + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
    logic [TOW-1:0] to_cnt_reg;
    logic           berr_reg;
`endif

    // Bus cycle sequencer: all outputs are registered here.
    always_ff @(posedge MCKR or negedge SYSRES_b) begin
        if (!SYSRES_b) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            be_reg       <= 2'b00;
            rw_reg       <= 1'b1;
            mem_en_reg   <= 1'b0;
            mem_we_reg   <= 1'b0;
            d_out_reg    <= '0;
            d_oe_reg     <= 1'b0;
            dtack_reg    <= 1'b1;
            wait_cnt_reg <= '0;
`ifdef VRESP_TIMEOUT_EN
            to_cnt_reg   <= '0;
            berr_reg     <= 1'b1;
`endif
        end else begin
            // The RAM strobe is a single-cycle pulse.
            mem_en_reg <= 1'b0;
            mem_we_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (!AS_b && !VRAM_b && (!UDS_b || !LDS_b)) begin
                        addr_reg  <= A;
                        wdata_reg <= D_in;
                        be_reg    <= {~UDS_b, ~LDS_b};
                        rw_reg    <= R_b_Vs_W;
                        state_reg <= ST_SLOT;
`ifdef VRESP_TIMEOUT_EN
                        to_cnt_reg <= '0;
`endif
                    end
                end

                ST_SLOT: begin
                    // An abort wins over a grant: a parked access is dropped.
                    if (AS_b) begin
                        state_reg <= ST_IDLE;
                    end else if (VRAC2) begin
                        mem_en_reg <= 1'b1;
                        mem_we_reg <= ~rw_reg;
                        state_reg  <= ST_MEM;
                    end
`ifdef VRESP_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        berr_reg  <= 1'b0;
                        state_reg <= ST_ERR;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end

                ST_MEM: begin
                    // A write strobed last cycle stands even if the CPU aborts.
                    if (AS_b) begin
                        state_reg <= ST_IDLE;
                    end else if (rw_reg) begin
                        state_reg <= ST_DATA;
                    end else if (WAIT_STATES > 0) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_HOLD;
                    end else begin
                        dtack_reg <= 1'b0;
                        state_reg <= ST_ACK;
                    end
                end

                ST_DATA: begin
                    // RAM data is valid one cycle after the strobe; take all 16 bits.
                    d_out_reg <= MEM_RDATA;
                    if (AS_b) begin
                        state_reg <= ST_IDLE;
                    end else if (WAIT_STATES > 0) begin
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_HOLD;
                    end else begin
                        dtack_reg <= 1'b0;
                        d_oe_reg  <= 1'b1;
                        state_reg <= ST_ACK;
                    end
                end

                ST_HOLD: begin
                    if (AS_b) begin
                        state_reg <= ST_IDLE;
                    end else if (wait_cnt_reg == WS_LAST) begin
                        dtack_reg <= 1'b0;
                        d_oe_reg  <= rw_reg;
                        state_reg <= ST_ACK;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end

                ST_ACK: begin
                    // DTACK_b and the data drive end on the edge that sees AS_b high.
                    if (AS_b) begin
                        dtack_reg <= 1'b1;
                        d_oe_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                ST_ERR: begin
                    if (AS_b) begin
`ifdef VRESP_TIMEOUT_EN
                        berr_reg  <= 1'b1;
`endif
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign D_out     = d_out_reg;
    assign D_OE      = d_oe_reg;
    assign DTACK_b   = dtack_reg;
    assign MEM_ADDR  = addr_reg;
    assign MEM_WDATA = wdata_reg;
    assign MEM_BE    = be_reg;
    assign MEM_EN    = mem_en_reg;
    assign MEM_WE    = mem_we_reg;

`ifdef VRESP_TIMEOUT_EN
    assign BERR_b = berr_reg;
`else
    assign BERR_b = 1'b1;
`endif

endmodule

// File: doc/vram_bus_responder.md
Name: vram_bus_responder

Overview:
- Bus-slave (responder) end of the 68010 asynchronous bus for the video RAM window; answers CPU cycles decoded as VRAM_b.
- Queues each CPU access into a video-granted slot (VRAC2), performs one synchronous RAM access with byte lanes, returns read data and generates DTACK_b with programmable wait states.
- Sits between the CPU address/data/strobe lines and the video RAM's CPU port; video fetch owns the RAM whenever VRAC2 is low.

Parameters:
- AW, 12, word-address width into video RAM (CPU A[AW:1]).
- WAIT_STATES, 0, extra MCKR cycles inserted before DTACK_b assertion (0..15).
- TIMEOUT, 64, slot-wait cycles before bus error; used only with VRESP_TIMEOUT_EN.

Ports:
- MCKR  in  1  system clock; all state on rising edge.
- SYSRES_b  in  1  asynchronous active-low reset.
- AS_b  in  1  CPU address strobe, synchronous to MCKR.
- UDS_b, LDS_b  in  1 each  upper/lower data strobes.
- R_b_Vs_W  in  1  1 = read, 0 = write.
- VRAM_b  in  1  decoded VRAM select, active low.
- A  in  AW  CPU word address.
- D_in  in  16  CPU write data.
- D_out  out  16  registered read data to CPU.
- D_OE  out  1  read-data drive enable.
- DTACK_b  out  1  data acknowledge, registered, active low.
- BERR_b  out  1  bus error, registered, active low.
- VRAC2  in  1  CPU slot grant from video timing; 1 = RAM free this cycle.
- MEM_ADDR  out  AW  RAM address.
- MEM_WDATA  out  16  RAM write data.
- MEM_BE  out  2  byte enables {upper, lower}.
- MEM_EN  out  1  one-cycle access strobe.
- MEM_WE  out  1  write qualifier, valid with MEM_EN.
- MEM_RDATA  in  16  RAM read data, valid one cycle after MEM_EN.

Behaviour:
- Reset (async, SYSRES_b=0): state IDLE; DTACK_b=1, BERR_b=1, D_OE=0, MEM_EN=0, MEM_WE=0, MEM_BE=00, D_out=0, MEM_ADDR=0, MEM_WDATA=0, counters 0. Reset mid-access abandons the cycle; no MEM_EN is issued after release until a new request.
- Request: sampled at an edge in IDLE when AS_b=0 & VRAM_b=0 & (UDS_b=0 | LDS_b=0). At that edge latch A→MEM_ADDR, D_in→MEM_WDATA, {~UDS_b,~LDS_b}→MEM_BE, R_b_Vs_W; go SLOT.
- SLOT: if VRAC2=1 at edge → MEM (MEM_EN=1, MEM_WE=~rw for exactly one cycle); otherwise stay.
- MEM: next edge → DATA for reads; for writes → HOLD if WAIT_STATES>0, else ACK.
- DATA: edge captures MEM_RDATA→D_out (all 16 bits; CPU ignores unstrobed lane) → HOLD or ACK.
- HOLD: counts WAIT_STATES edges, then ACK.
- ACK: DTACK_b=0; D_OE=1 on reads. Stay until AS_b=1 sampled → IDLE; DTACK_b and D_OE deassert at that same edge.
- Latency with WAIT_STATES=0, VRAC2 held high, request sampled at edge n: write DTACK_b low after edge n+2; read D_out valid and DTACK_b low after edge n+3. Each wait state adds one cycle.
- Abort: AS_b=1 sampled in SLOT/MEM/DATA/HOLD → IDLE, no DTACK_b. A write already strobed (MEM_EN issued) stands; a pending SLOT access is dropped with no MEM_EN.
- Back-to-back: a new request requires a return to IDLE, so at least one sampled AS_b=1 between cycles. DTACK_b is never low across two CPU cycles.
- VRAC2 toggling while SLOT: only the edge-sampled value matters. VRAC2 is ignored outside SLOT.
- Requests with VRAM_b=1 or both DS high are ignored; all outputs stay idle.

Optional Feature:
- VRESP_TIMEOUT_EN defined: SLOT counts cycles with VRAC2=0. At TIMEOUT consecutive cycles → ERR state with BERR_b=0 and no MEM_EN. ERR holds until AS_b=1 sampled, then → IDLE with BERR_b=1 at that edge. Counter clears on entering SLOT.
- Not defined: BERR_b constant 1; SLOT waits indefinitely.

Test Plan:
- Reset mid-access: assert SYSRES_b=0 while in HOLD → all outputs at reset values immediately; no MEM_EN after release.
- Write, VRAC2=1, WAIT_STATES=0, A=0x123, D_in=0xBEEF, UDS_b=LDS_b=0 → one MEM_EN with MEM_WE=1, MEM_BE=11, MEM_ADDR=0x123, MEM_WDATA=0xBEEF; DTACK_b low after edge n+2, high one edge after AS_b=1.
- Read, MEM_RDATA=0x5A5A, LDS_b only, WAIT_STATES=2 → MEM_BE=01, MEM_WE=0; D_out=0x5A5A and D_OE=1 with DTACK_b low after edge n+5.
- Slot starvation: VRAC2=0 for 10 cycles, then 1 → MEM_EN exactly once, on the edge after VRAC2 first sampled 1; DTACK_b delayed 10 cycles relative to the free-slot case.
- Abort: AS_b released during SLOT → no MEM_EN, no DTACK_b, back in IDLE; next request proceeds normally.
- VRESP_TIMEOUT_EN with TIMEOUT=64, VRAC2=0 forever → BERR_b low after 64 SLOT cycles, no MEM_EN, DTACK_b stays 1; BERR_b returns to 1 on the edge after AS_b=1 is sampled.
